// File: rtl/pot_sampler_if.sv
// Bundles the pot sampler's controller-side and ADC-side signals.
// master = the sampler itself, slave = whoever sits on the other end.
interface pot_sampler_if #(
  parameter int cant_bits = 16
);
  logic                        En;
  logic                        MISO;
  logic                        CS_n;
  logic                        SCLK;
  logic signed [cant_bits-1:0] Pot;
  logic                        Rx_En;
  logic                        Busy;
  logic                        Overrun;

  modport master (
    input  En, MISO,
    output CS_n, SCLK, Pot, Rx_En, Busy, Overrun
  );

  modport slave (
    output En, MISO,
    input  CS_n, SCLK, Pot, Rx_En, Busy, Overrun
  );
endinterface

// File: rtl/pot_sampler.sv
// Periodic SPI reader for a 12-bit potentiometer ADC: every SAMPLE_PERIOD cycles it
// clocks out one 16-bit frame and presents the result MSB-aligned below the sign bit.
module pot_sampler #(
  parameter int cant_bits     = 16,
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 100000
) (
  input  logic          Clk_G,
  input  logic          Rst_G,
  pot_sampler_if.master bus
);

  localparam int CNT_W = $clog2(SAMPLE_PERIOD);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           div_q, div_d;
  logic [4:0]           edges_q, edges_d;
  logic [10:0]          shift_q, shift_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sclk_q, sclk_d;
  logic                 overrun_q, overrun_d;
  logic [cant_bits-1:0] pot_q, pot_d;
  logic                 tick;
  logic [11:0]          data_w;

  // The count rests at zero while sampling is disabled, so the first tick
  // always lands a full period after En rises.
  always_comb begin
    tick  = bus.En && (cnt_q == CNT_W'(SAMPLE_PERIOD - 1));
    cnt_d = '0;
    if (bus.En && !tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Eleven held bits plus the live MISO bit form the sample on the last rising edge.
  assign data_w = {shift_q, bus.MISO};

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    edges_d   = edges_q;
    shift_d   = shift_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    pot_d     = pot_q;
    overrun_d = overrun_q | (tick && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = CONV;
          cs_n_d  = 1'b0;
          div_d   = '0;
          edges_d = '0;
        end
      end
      CONV: begin
        if (div_q == 8'(CLK_DIV - 1)) begin
          div_d   = '0;
          sclk_d  = !sclk_q;
          edges_d = edges_q + 5'd1;
          if (!sclk_q) begin
            shift_d = {shift_q[9:0], bus.MISO};
          end
          if (edges_q == 5'd31) begin
            state_d = DONE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b1;
            pot_d   = cant_bits'(data_w) << (cant_bits - 13);
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_G) begin
    if (!Rst_G) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      edges_q   <= '0;
      shift_q   <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      overrun_q <= 1'b0;
      pot_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      edges_q   <= edges_d;
      shift_q   <= shift_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      overrun_q <= overrun_d;
      pot_q     <= pot_d;
    end
  end

  assign bus.CS_n    = cs_n_q;
  assign bus.SCLK    = sclk_q;
  assign bus.Pot     = pot_q;
  assign bus.Rx_En   = (state_q == DONE);
  assign bus.Busy    = (state_q != IDLE);
  assign bus.Overrun = overrun_q;

endmodule
